// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared state encoding, symbol constants and table selects for the block decoder
package jpeg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FEED, ST_WAIT, ST_MAG, ST_EMIT, ST_DONE} state_t;
  localparam logic [7:0] SYM_EOB = 8'h00;
  localparam logic [7:0] SYM_ZRL = 8'hF0;
  localparam logic [3:0] MAX_DC_SIZE = 4'd11;
  localparam logic [6:0] BLK_LAST = 7'd63;
  localparam logic TBL_DC = 1'b0;
  localparam logic TBL_AC = 1'b1;
endpackage

// File: rtl/jpeg_mag_extend.sv
// jpeg_mag_extend: turns an S-bit JPEG magnitude field into a signed coefficient
module jpeg_mag_extend #(
  parameter int COEF_W = 16
) (
  input  logic [3:0]               s,
  input  logic [10:0]              mag,
  output logic signed [COEF_W-1:0] val
);
  logic [11:0] lim;
  logic        hi;
  logic [12:0] v;
  // a clear top bit means a negative value offset by 2^S-1
  always_comb begin
    lim = (12'd1 << s) - 12'd1;
    hi  = |({1'b0, mag} & (lim ^ (lim >> 1)));
    v   = hi ? {2'b0, mag} : {2'b0, mag} - {1'b0, lim};
    val = COEF_W'($signed(v));
  end
endmodule

// File: rtl/jpeg_block_decode_ctrl.sv
// jpeg_block_decode_ctrl: sequences entropy decoding of one 8x8 block around a Huffman decoder
module jpeg_block_decode_ctrl #(
  parameter int NUM_COMP = 3,
  parameter int COEF_W   = 16,
  parameter int HUFF_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     blk_start,
  input  logic [1:0]               comp_id,
  input  logic                     pred_clr,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic                     huff_enable,
  output logic                     huff_bit,
  output logic                     huff_bit_valid,
  output logic                     huff_tbl_load,
  output logic                     huff_tbl_sel,
  input  logic [7:0]               sym_in,
  input  logic                     sym_valid,
  output logic                     coef_valid,
  output logic [5:0]               coef_idx,
  output logic signed [COEF_W-1:0] coef_val,
  output logic                     blk_done,
  output logic                     blk_err
);
  import jpeg_pkg::*;
  localparam int WW = $clog2(HUFF_LAT + 1);
  state_t                   state_q, state_d;
  logic [1:0]               comp_q, comp_d;
  logic                     sel_q, sel_d, err_q, err_d;
  logic [6:0]               idx_q, idx_d, idx_r, idx_z;
  logic [3:0]               s_q, s_d, cnt_q, cnt_d;
  logic [10:0]              mag_q, mag_d;
  logic [WW-1:0]            wcnt_q, wcnt_d;
  logic signed [COEF_W-1:0] pred_q [NUM_COMP];
  logic signed [COEF_W-1:0] pred_d [NUM_COMP];
  logic signed [COEF_W-1:0] ext_val;

  jpeg_mag_extend #(.COEF_W(COEF_W)) u_ext (.s(s_q), .mag(mag_q), .val(ext_val));

  // next-state, datapath updates and per-state output strobes
  always_comb begin
    state_d = state_q;
    comp_d = comp_q;
    sel_d = sel_q;
    err_d = err_q;
    idx_d = idx_q;
    s_d = s_q;
    cnt_d = cnt_q;
    mag_d = mag_q;
    wcnt_d = wcnt_q;
    pred_d = pred_q;
    bit_ready = 1'b0;
    huff_enable = 1'b0;
    huff_bit = 1'b0;
    huff_bit_valid = 1'b0;
    huff_tbl_load = 1'b0;
    coef_valid = 1'b0;
    coef_idx = '0;
    coef_val = '0;
    blk_done = 1'b0;
    blk_err = 1'b0;
    idx_r = idx_q + {3'b0, sym_in[7:4]};
    idx_z = idx_q + 7'd16;
    case (state_q)
      ST_IDLE: begin
        if (pred_clr) for (int i = 0; i < NUM_COMP; i++) pred_d[i] = '0;
        if (blk_start) begin
          comp_d = comp_id;
          sel_d = TBL_DC;
          idx_d = '0;
          err_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        huff_tbl_load = 1'b1;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        huff_enable = 1'b1;
        bit_ready = 1'b1;
        huff_bit_valid = bit_valid;
        huff_bit = bit_in & bit_valid;
        wcnt_d = '0;
        state_d = bit_valid ? ST_WAIT : ST_FEED;
      end
      ST_WAIT: begin
        huff_enable = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if (sym_valid) begin
          s_d = sym_in[3:0];
          cnt_d = sym_in[3:0];
          mag_d = '0;
          if (sym_in[3:0] > MAX_DC_SIZE) begin
            err_d = 1'b1;
            state_d = ST_DONE;
          end else if (sel_q == TBL_DC) begin
            state_d = (sym_in[3:0] == 4'd0) ? ST_EMIT : ST_MAG;
          end else if (sym_in == SYM_EOB) begin
            state_d = ST_DONE;
          end else if (sym_in == SYM_ZRL) begin
            idx_d = idx_z;
            err_d = idx_z > BLK_LAST;
            state_d = (idx_z > BLK_LAST) ? ST_DONE : ST_FEED;
          end else begin
            idx_d = idx_r;
            err_d = idx_r > BLK_LAST;
            state_d = (idx_r > BLK_LAST) ? ST_DONE : (sym_in[3:0] == 4'd0) ? ST_EMIT : ST_MAG;
          end
        end else if (wcnt_q == WW'(HUFF_LAT - 1)) begin
          state_d = ST_FEED;
        end
      end
      ST_MAG: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          mag_d = {mag_q[9:0], bit_in};
          cnt_d = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? ST_EMIT : ST_MAG;
        end
      end
      ST_EMIT: begin
        coef_valid = 1'b1;
        if (sel_q == TBL_DC) begin
          coef_val = pred_q[comp_q] + ext_val;
          pred_d[comp_q] = coef_val;
          idx_d = 7'd1;
          sel_d = TBL_AC;
          state_d = ST_LOAD;
        end else begin
          coef_val = ext_val;
          coef_idx = idx_q[5:0];
          idx_d = idx_q + 7'd1;
          state_d = (idx_q == BLK_LAST) ? ST_DONE : ST_FEED;
        end
      end
      ST_DONE: begin
        blk_done = 1'b1;
        blk_err = err_q;
        err_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign huff_tbl_sel = sel_q;

  // state and datapath registers; reset also drops predictors and any partial magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      comp_q <= '0;
      sel_q <= TBL_DC;
      err_q <= 1'b0;
      idx_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      mag_q <= '0;
      wcnt_q <= '0;
      for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
    end else begin
      state_q <= state_d;
      comp_q <= comp_d;
      sel_q <= sel_d;
      err_q <= err_d;
      idx_q <= idx_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      mag_q <= mag_d;
      wcnt_q <= wcnt_d;
      pred_q <= pred_d;
    end
  end
endmodule

// File: tb/tb_jpeg_block_decode_ctrl.sv
// tb_jpeg_block_decode_ctrl: table-driven block vectors plus full-block and reset sequences
module tb_jpeg_block_decode_ctrl;
  logic clk = 0, rst_n = 0, blk_start = 0, pred_clr = 0, bit_in = 0, bit_valid = 0, sym_valid = 0;
  logic [1:0] comp_id = 0;
  logic [7:0] sym_in = 0;
  logic bit_ready, huff_enable, huff_bit, huff_bit_valid, huff_tbl_load, huff_tbl_sel;
  logic coef_valid, blk_done, blk_err;
  logic [5:0] coef_idx;
  logic signed [15:0] coef_val;

  jpeg_block_decode_ctrl #(.NUM_COMP(3), .COEF_W(16), .HUFF_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .blk_start(blk_start), .comp_id(comp_id), .pred_clr(pred_clr),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready), .huff_enable(huff_enable),
    .huff_bit(huff_bit), .huff_bit_valid(huff_bit_valid), .huff_tbl_load(huff_tbl_load),
    .huff_tbl_sel(huff_tbl_sel), .sym_in(sym_in), .sym_valid(sym_valid), .coef_valid(coef_valid),
    .coef_idx(coef_idx), .coef_val(coef_val), .blk_done(blk_done), .blk_err(blk_err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] comp;
    logic pclr, stall, eerr;
    logic [3:0] nsym;
    logic [1:0] ncoef;
    logic [0:7][7:0] sym;
    logic [0:7][10:0] bits;
    logic [0:2][5:0] eidx;
    logic [0:2][15:0] eval;
  } vec_t;

  vec_t vecs [11];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, err_cnt = 0, load_cnt = 0, last_coef_cyc = 0, done_cyc = 0;
  logic [5:0] q_idx [$];
  logic [15:0] q_val [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (coef_valid) begin
      q_idx.push_back(coef_idx);
      q_val.push_back(coef_val);
      last_coef_cyc = cyc;
    end
    if (blk_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (blk_err) err_cnt++;
    end
    if (huff_tbl_load) load_cnt++;
  end

  function automatic vec_t mk(input int c, p, st, e, ns, nc, input logic [63:0] s, input logic [87:0] b,
                              input logic [17:0] ix, input logic [47:0] ev);
    vec_t r;
    r.comp = 2'(c); r.pclr = 1'(p); r.stall = 1'(st); r.eerr = 1'(e);
    r.nsym = 4'(ns); r.ncoef = 2'(nc); r.sym = s; r.bits = b; r.eidx = ix; r.eval = ev;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bit_ready, huff_enable, huff_bit, huff_bit_valid, huff_tbl_load, huff_tbl_sel,
                 coef_valid, coef_idx, coef_val, blk_done, blk_err});
  endfunction

  task automatic put_bit(input logic b, input bit code, input bit stall);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      sym_valid = 0;
      bit_in = b;
      bit_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ok = code ? huff_bit_valid : (bit_valid && bit_ready && !huff_enable);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL bit_accept: got timeout required accept");
    end
  endtask

  task automatic send_sym(input logic [7:0] s, input logic [10:0] bits, input int nb, input bit stall);
    put_bit(1'b0, 1, stall);
    @(negedge clk); bit_valid = 0;
    @(negedge clk); sym_in = s; sym_valid = 1;
    for (int k = nb - 1; k >= 0; k--) put_bit(bits[k], 0, stall);
  endtask

  task automatic start_block(input logic [1:0] c, input logic p);
    @(negedge clk);
    q_idx.delete();
    q_val.delete();
    comp_id = c; pred_clr = p; blk_start = 1;
    @(negedge clk);
    blk_start = 0; pred_clr = 0;
  endtask

  task automatic wait_done(input int d0);
    for (int n = 0; n < 300 && done_cnt == d0; n++) begin
      @(negedge clk);
      bit_valid = 0; sym_valid = 0;
      #1;
    end
    chk("blk_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    vec_t v;
    int d0, e0, l0, nb, bad;
    vecs[0]  = mk(0, 0, 0, 0, 2, 1, {8'h03, 8'h00, 48'd0}, {11'd5, 77'd0}, 18'd0, {16'd5, 32'd0});
    vecs[1]  = mk(0, 0, 0, 0, 2, 1, {8'h02, 8'h00, 48'd0}, {11'd1, 77'd0}, 18'd0, {16'd3, 32'd0});
    vecs[2]  = mk(0, 1, 0, 0, 2, 1, {8'h02, 8'h00, 48'd0}, {11'd1, 77'd0}, 18'd0, {16'hFFFE, 32'd0});
    vecs[3]  = mk(1, 0, 0, 0, 4, 3, {8'h01, 8'h21, 8'h12, 8'h00, 32'd0}, {11'd1, 11'd0, 11'd3, 55'd0},
                  {6'd0, 6'd3, 6'd5}, {16'd1, 16'hFFFF, 16'd3});
    vecs[4]  = mk(2, 0, 0, 0, 2, 1, {8'h00, 8'h00, 48'd0}, 88'd0, 18'd0, 48'd0);
    vecs[5]  = mk(0, 0, 0, 0, 2, 1, {8'h0B, 8'h00, 48'd0}, {11'd1024, 77'd0}, 18'd0, {16'd1022, 32'd0});
    vecs[6]  = mk(0, 0, 0, 1, 1, 0, {8'h0C, 56'd0}, 88'd0, 18'd0, 48'd0);
    vecs[7]  = mk(0, 0, 0, 0, 3, 2, {8'h01, 8'h05, 8'h00, 40'd0}, 88'd0, {6'd0, 6'd1, 6'd0},
                  {16'd1021, 16'hFFE1, 16'd0});
    vecs[8]  = mk(1, 0, 0, 1, 6, 2, {8'h00, 8'hF0, 8'hF0, 8'hF0, 8'h01, 8'hE1, 16'd0},
                  {44'd0, 11'd1, 33'd0}, {6'd0, 6'd49, 6'd0}, {16'd1, 16'd1, 16'd0});
    vecs[9]  = mk(2, 0, 0, 1, 5, 1, {8'h00, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 24'd0}, 88'd0, 18'd0, 48'd0);
    vecs[10] = mk(1, 0, 1, 0, 4, 3, {8'h01, 8'h21, 8'h12, 8'h00, 32'd0}, {11'd1, 11'd0, 11'd3, 55'd0},
                  {6'd0, 6'd3, 6'd5}, {16'd2, 16'hFFFF, 16'd3});

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1;
    @(negedge clk); #1;
    chk("idle_outputs", outs(), 0);

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      d0 = done_cnt; e0 = err_cnt;
      start_block(v.comp, v.pclr);
      for (int k = 0; k < int'(v.nsym); k++) begin
        nb = (v.eerr && k == int'(v.nsym) - 1) ? 0 : int'(v.sym[k][3:0]);
        send_sym(v.sym[k], v.bits[k], nb, v.stall);
      end
      wait_done(d0);
      chk($sformatf("v%0d_ncoef", i), q_idx.size(), int'(v.ncoef));
      for (int k = 0; k < int'(v.ncoef) && k < q_idx.size(); k++) begin
        chk($sformatf("v%0d_idx%0d", i, k), int'(q_idx[k]), int'(v.eidx[k]));
        chk($sformatf("v%0d_val%0d", i, k), int'($signed(q_val[k])), int'($signed(v.eval[k])));
      end
      chk($sformatf("v%0d_err", i), err_cnt - e0, int'(v.eerr));
    end

    d0 = done_cnt; l0 = load_cnt;
    start_block(2, 0);
    send_sym(8'h00, 11'd0, 0, 0);
    for (int k = 0; k < 63; k++) send_sym(8'h01, 11'd1, 1, 0);
    wait_done(d0);
    chk("full_ncoef", q_idx.size(), 64);
    bad = 0;
    for (int k = 0; k < q_idx.size(); k++)
      if (int'(q_idx[k]) != k || int'($signed(q_val[k])) != (k == 0 ? 0 : 1)) bad++;
    chk("full_bad_coefs", bad, 0);
    chk("full_done_latency", done_cyc - last_coef_cyc, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("full_loads", load_cnt - l0, 2);
    chk("full_tbl_load_idle", int'(huff_tbl_load), 0);
    chk("full_tbl_sel_ac", int'(huff_tbl_sel), 1);

    d0 = done_cnt;
    start_block(0, 0);
    send_sym(8'h03, 11'd1, 1, 0);
    @(negedge clk); bit_valid = 0; #1;
    chk("mid_mag_state", int'({bit_ready, huff_enable}), 2);
    rst_n = 0; #1;
    chk("mid_rst_outputs", outs(), 0);
    @(negedge clk); rst_n = 1; #1;
    chk("post_rst_outputs", outs(), 0);
    chk("aborted_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    start_block(0, 0);
    send_sym(8'h01, 11'd1, 1, 0);
    send_sym(8'h00, 11'd0, 0, 0);
    wait_done(d0);
    chk("post_rst_ncoef", q_idx.size(), 1);
    if (q_val.size() > 0) chk("post_rst_pred_val", int'($signed(q_val[0])), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jpeg_block_decode_ctrl.md
Name: jpeg_block_decode_ctrl

Overview:
Sequences one 8x8 block of entropy decoding around the Huffman symbol decoder. Steers bitstream bits either into the Huffman decoder (code phase) or into its own magnitude register (extra-bit phase). Selects and loads the DC/AC table, applies DC prediction per component, and tracks run-length and zigzag index. Emits non-zero coefficients to the dequant/zigzag buffer, which pre-clears each block.

Parameters:
NUM_COMP, 3, number of components with independent DC predictors
COEF_W, 16, signed coefficient width
HUFF_LAT, 2, cycles from a forwarded bit to a valid Huffman decoder response

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
blk_start  in  1  pulse: begin decoding one block (accepted in IDLE only)
comp_id  in  2  component of the block, sampled on blk_start
pred_clr  in  1  pulse: zero all DC predictors (restart marker); ignored while busy
bit_in  in  1  bitstream bit
bit_valid  in  1  bit_in valid
bit_ready  out  1  controller accepts bit this cycle
huff_enable  out  1  enable to Huffman decoder
huff_bit  out  1  bit forwarded to decoder
huff_bit_valid  out  1  forwarded-bit strobe
huff_tbl_load  out  1  pulse: decoder loads table selected by huff_tbl_sel
huff_tbl_sel  out  1  0=DC table, 1=AC table
sym_in  in  8  decoded symbol
sym_valid  in  1  symbol strobe
coef_valid  out  1  coefficient strobe
coef_idx  out  6  zigzag index
coef_val  out  COEF_W  signed coefficient
blk_done  out  1  1-cycle pulse at end of block
blk_err  out  1  1-cycle pulse, coincident with blk_done, on index overflow or S>11

Behaviour:
- Reset: all outputs 0, state IDLE, predictors 0, idx 0.
- States: IDLE, LOAD, FEED, WAIT, MAG, EMIT, DONE.
- IDLE: on blk_start, latch comp_id, set huff_tbl_sel=0, go to LOAD. pred_clr clears predictors in IDLE only.
- LOAD: huff_tbl_load=1 for exactly one cycle. Next cycle goes to FEED (table settled).
- FEED:
  - huff_enable=1, bit_ready=1.
  - On bit_valid: huff_bit=bit_in, huff_bit_valid=1, then go to WAIT.
  - No other bit is forwarded until WAIT completes.
- WAIT:
  - huff_enable=1, bit_ready=0, lasts HUFF_LAT cycles.
  - If sym_valid is seen in the window, latch R=sym[7:4], S=sym[3:0]; otherwise return to FEED.
- Symbol dispatch, DC phase (sel=0):
  - S=0: diff=0, go to EMIT.
  - S>11: error, go to DONE.
  - Otherwise go to MAG with S bits to read.
- Symbol dispatch, AC phase:
  - R=0,S=0 (EOB): go to DONE.
  - R=15,S=0 (ZRL): idx+=16, back to FEED.
  - Otherwise idx+=R, go to MAG.
  - If idx+R>63, or if ZRL lands beyond 63: blk_err, go to DONE.
- MAG:
  - bit_ready=1, huff_enable=0.
  - Shift S bits MSB-first into mag; bit_valid low stalls.
  - Value: if mag[S-1]=1 then V=mag, else V=mag-(2^S-1). Sign-extend to COEF_W.
- EMIT:
  - DC: coef_val = pred[comp] + V (COEF_W wrap), pred[comp] updated, coef_idx=0. Then idx=1, sel=1, go to LOAD.
  - AC: coef_val=V, coef_idx=idx, then idx+=1. If the emitted idx was 63, go to DONE (no EOB expected). Otherwise go to FEED.
  - coef_valid lasts one cycle. No backpressure: the consumer must accept every cycle.
- DONE:
  - blk_done for one cycle, blk_err if flagged, then IDLE.
  - The AC table stays loaded; the next block reloads DC via LOAD.
- blk_start while busy: ignored.
- rst_n mid-block: immediate return to IDLE. Predictors cleared. A partially shifted mag is discarded.
- Throughput bound: (1+HUFF_LAT) cycles per code bit plus 1 per magnitude bit.

Decomposition:
- Shared package jpeg_pkg holds:
  - state enum for this FSM;
  - constants SYM_EOB=8'h00, SYM_ZRL=8'hF0, MAX_DC_SIZE=11, BLK_LAST=63;
  - TBL_DC/TBL_AC encodings.
- One sub-module, jpeg_mag_extend: combinational (S, mag) -> signed COEF_W value. Shared with a future progressive-mode path.

Test Plan:
- DC-only block: DC symbol 0x03 with bits 101, then AC EOB 0x00, comp 0, pred 0 -> coef_idx=0, coef_val=5, blk_done, pred[0]=5.
- Negative DC and prediction: second block comp 0, symbol 0x02 with bits 01 -> diff=-2, coef_val=3. Then pred_clr, then same block -> coef_val=-2.
- AC run: after DC, AC symbol 0x21 with bit 0 -> coef_idx=3, coef_val=-1. Then symbol 0x12 with bits 11 -> coef_idx=5, coef_val=3. Then EOB -> blk_done.
- ZRL: AC 0xF0 ×3, then 0x01 with bit 1 -> coef_idx=49, val=1. Then 0xE1 with bit 1 -> idx 64 overflow -> blk_err and blk_done, no coef_valid.
- Full block: 63 AC symbols 0x01 with bit 1, no EOB -> 63 coef_valid at idx 1..63, blk_done right after idx 63, huff_tbl_load=0 afterwards.
- Stalls and reset: bit_valid toggling 50% during FEED and MAG gives identical coefficients. rst_n asserted mid-MAG -> all outputs 0 next cycle, predictors 0.
